// File: rtl/summator_pkg.sv
// rtl/summator_pkg.sv - shared FSM state type, width limits and index sizing for the summator family
package summator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } summator_state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // Bit-index register width: max(1, clog2(width)).
  function automatic int index_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/summator_serial_if.sv
// rtl/summator_serial_if.sv - operand/result handshake bundle for summator_serial
// SUMMATOR_SERIAL_SUBTRACT_EN adds the input_subtract request bit.
interface summator_serial_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] input_number0;
  logic [WIDTH-1:0] input_number1;
  logic             input_carry;
  logic             input_start;
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
  logic             input_subtract;
`endif
  logic             output_busy;
  logic [WIDTH-1:0] output_sum;
  logic             output_carry;
  logic             output_calculated;

  modport master (
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
    output input_subtract,
`endif
    output input_number0, input_number1, input_carry, input_start,
    input  output_busy, output_sum, output_carry, output_calculated
  );

  modport slave (
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
    input  input_subtract,
`endif
    input  input_number0, input_number1, input_carry, input_start,
    output output_busy, output_sum, output_carry, output_calculated
  );

endinterface

// File: rtl/summator_full_bit1.sv
// rtl/summator_full_bit1.sv - combinational one-bit full-adder cell
module summator_full_bit1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/summator_serial.sv
// rtl/summator_serial.sv - bit-serial WIDTH-bit adder, one bit per clock through a single full-adder cell
// SUMMATOR_SERIAL_SUBTRACT_EN adds an A-B mode selected by input_subtract at start.
module summator_serial
  import summator_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SERIAL_NUMBER = 0
) (
  input  logic             input_clk,
  input  logic             input_reset_n,
  summator_serial_if.slave bus
);

  localparam int IDX_W = index_width(WIDTH);

  summator_state_t  state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, psum_q, psum_next, sum_q;
  logic [WIDTH-1:0] a_load, b_load;
  logic             c_load;
  logic             carry_q, cout_q;
  logic [IDX_W-1:0] idx_q;
  logic             fa_sum, fa_cout, last_bit;

  always_comb begin
    a_load = bus.input_number0;
    b_load = bus.input_number1;
    c_load = bus.input_carry;
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
    // Two's-complement subtract: A + ~B + 1.
    if (bus.input_subtract) begin
      b_load = ~bus.input_number1;
      c_load = 1'b1;
    end
`endif
  end

  summator_full_bit1 u_full_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

  if (WIDTH == 1) begin : g_psum_w1
    assign psum_next = fa_sum;
  end else begin : g_psum_wn
    assign psum_next = {fa_sum, psum_q[WIDTH-1:1]};
  end

  always_ff @(posedge input_clk or negedge input_reset_n) begin
    if (!input_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.input_start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk or negedge input_reset_n) begin
    if (!input_reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.input_start) begin
          a_q     <= a_load;
          b_q     <= b_load;
          carry_q <= c_load;
          psum_q  <= '0;
          idx_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          psum_q  <= psum_next;
          carry_q <= fa_cout;
          if (last_bit) begin
            sum_q  <= psum_next;
            cout_q <= fa_cout;
          end else begin
            idx_q  <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.output_busy       = (state_q != IDLE);
    bus.output_calculated = (state_q == DONE);
    bus.output_sum        = sum_q;
    bus.output_carry      = cout_q;
  end

endmodule

// File: tb/tb_summator_serial.sv
// tb/tb_summator_serial.sv - randomized self-checking bench for summator_serial at WIDTH 8, 1, 16 and 64
// Build with SUMMATOR_SERIAL_SUBTRACT_EN defined to exercise the subtract mode.
module tb_summator_serial;
  import summator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  summator_serial_if #(.WIDTH(8))         bus8  ();
  summator_serial_if #(.WIDTH(WIDTH_MIN)) bus1  ();
  summator_serial_if #(.WIDTH(16))        bus16 ();
  summator_serial_if #(.WIDTH(WIDTH_MAX)) bus64 ();

  summator_serial #(.WIDTH(8),         .SERIAL_NUMBER(0)) u_w8  (.input_clk(clk), .input_reset_n(rst_n), .bus(bus8.slave));
  summator_serial #(.WIDTH(WIDTH_MIN), .SERIAL_NUMBER(1)) u_w1  (.input_clk(clk), .input_reset_n(rst_n), .bus(bus1.slave));
  summator_serial #(.WIDTH(16),        .SERIAL_NUMBER(2)) u_w16 (.input_clk(clk), .input_reset_n(rst_n), .bus(bus16.slave));
  summator_serial #(.WIDTH(WIDTH_MAX), .SERIAL_NUMBER(3)) u_w64 (.input_clk(clk), .input_reset_n(rst_n), .bus(bus64.slave));

  task automatic check_value(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      0: return 8;
      1: return WIDTH_MIN;
      2: return 16;
      default: return WIDTH_MAX;
    endcase
  endfunction

  // Unsigned reference: {carry, sum} = A + B + cin, or A - B mod 2^w with carry = no borrow.
  function automatic logic [64:0] ref_result(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic cin, input logic sub);
    logic [63:0] m;
    logic [64:0] t;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & m;
    b = b & m;
    if (sub) return {a >= b, (a - b) & m};
    t = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    return {t[w], t[63:0] & m};
  endfunction

  task automatic set_inputs(input int sel, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub, input logic start);
    case (sel)
      0: begin bus8.input_number0  = a[7:0];  bus8.input_number1  = b[7:0];  bus8.input_carry  = cin; bus8.input_start  = start; end
      1: begin bus1.input_number0  = a[0:0];  bus1.input_number1  = b[0:0];  bus1.input_carry  = cin; bus1.input_start  = start; end
      2: begin bus16.input_number0 = a[15:0]; bus16.input_number1 = b[15:0]; bus16.input_carry = cin; bus16.input_start = start; end
      default: begin bus64.input_number0 = a; bus64.input_number1 = b; bus64.input_carry = cin; bus64.input_start = start; end
    endcase
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
    case (sel)
      0: bus8.input_subtract  = sub;
      1: bus1.input_subtract  = sub;
      2: bus16.input_subtract = sub;
      default: bus64.input_subtract = sub;
    endcase
`else
    if (sub) $display("subtract requested on an add-only build");
`endif
  endtask

  function automatic logic [64:0] get_result(input int sel);
    case (sel)
      0: return {bus8.output_carry,  64'(bus8.output_sum)};
      1: return {bus1.output_carry,  64'(bus1.output_sum)};
      2: return {bus16.output_carry, 64'(bus16.output_sum)};
      default: return {bus64.output_carry, bus64.output_sum};
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return bus8.output_busy;
      1: return bus1.output_busy;
      2: return bus16.output_busy;
      default: return bus64.output_busy;
    endcase
  endfunction

  function automatic logic get_calc(input int sel);
    case (sel)
      0: return bus8.output_calculated;
      1: return bus1.output_calculated;
      2: return bus16.output_calculated;
      default: return bus64.output_calculated;
    endcase
  endfunction

  // One complete operation from an idle DUT; operands are scrambled while it runs.
  task automatic do_op(input int sel, input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic sub, input string tag, output logic [64:0] res);
    int          w;
    int          k;
    logic        seen;
    logic [64:0] exp;
    w    = width_of(sel);
    exp  = ref_result(w, a, b, cin, sub);
    k    = 0;
    seen = 1'b0;
    @(negedge clk);
    set_inputs(sel, a, b, cin, sub, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_inputs(sel, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sub, 1'b0);
    if (w > 1) check_value({tag, "_busy_run"}, 65'(get_busy(sel)), 65'd1);
    while (!seen && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (get_calc(sel)) seen = 1'b1;
    end
    check_value({tag, "_latency"}, 65'(k), 65'(w));
    res = get_result(sel);
    check_value({tag, "_result"}, res, exp);
    check_value({tag, "_not_x"}, 65'($isunknown(res)), 65'd0);
    check_value({tag, "_busy_done"}, 65'(get_busy(sel)), 65'd1);
    @(posedge clk);
    @(negedge clk);
    check_value({tag, "_idle"}, {63'd0, get_busy(sel), get_calc(sel)}, 65'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] r;
    logic [7:0]  oa [3];
    logic [7:0]  ob [3];
    logic        oc [3];
    int          last_pulse;
    logic        calc;

    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) set_inputs(s, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check_value($sformatf("reset_flags_%0d", s), {63'd0, get_busy(s), get_calc(s)}, 65'd0);
      check_value($sformatf("reset_result_%0d", s), get_result(s), 65'd0);
    end
    rst_n = 1'b1;

    // Reset mid-RUN drops the operation and clears the outputs.
    do_op(0, 64'hC3, 64'h5A, 1'b1, 1'b0, "pre_reset", r);
    @(negedge clk);
    set_inputs(0, 64'h5A, 64'h33, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_inputs(0, 64'h5A, 64'h33, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("midrun_busy", 65'(get_busy(0)), 65'd1);
    rst_n = 1'b0;
    #1;
    check_value("midrun_reset_busy", 65'(get_busy(0)), 65'd0);
    check_value("midrun_reset_calc", 65'(get_calc(0)), 65'd0);
    check_value("midrun_reset_result", get_result(0), 65'd0);
    @(posedge clk);
    @(negedge clk);
    check_value("midrun_no_pulse", 65'(get_calc(0)), 65'd0);
    rst_n = 1'b1;
    do_op(0, 64'h5A, 64'h33, 1'b0, 1'b0, "restart", r);
    check_value("restart_value", r, {1'b0, 64'h8D});

    do_op(0, 64'hFF, 64'h01, 1'b0, 1'b0, "carry_ripple", r);
    check_value("carry_ripple_value", r, {1'b1, 64'h00});
    do_op(0, 64'hFF, 64'hFF, 1'b1, 1'b0, "carry_full", r);
    check_value("carry_full_value", r, {1'b1, 64'hFF});

    do_op(1, 64'h1, 64'h1, 1'b1, 1'b0, "w1_ones", r);
    check_value("w1_ones_value", r, {1'b1, 64'h1});
    do_op(1, 64'h0, 64'h0, 1'b0, 1'b0, "w1_zeros", r);
    check_value("w1_zeros_value", r, 65'd0);

`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
    do_op(0, 64'h10, 64'h01, 1'b0, 1'b1, "sub_pos", r);
    check_value("sub_pos_value", r, {1'b1, 64'h0F});
    do_op(0, 64'h01, 64'h02, 1'b1, 1'b1, "sub_neg", r);
    check_value("sub_neg_value", r, {1'b0, 64'hFF});
`endif

    // Start held high: accepts every WIDTH+2 cycles, operands scrambled in between.
    for (int i = 0; i < 3; i++) begin
      oa[i] = 8'($urandom);
      ob[i] = 8'($urandom);
      oc[i] = 1'($urandom_range(0, 1));
    end
    last_pulse = -1;
    for (int c = 0; c < 30; c++) begin
      if (c % 10 == 0) set_inputs(0, 64'(oa[c/10]), 64'(ob[c/10]), oc[c/10], 1'b0, 1'b1);
      else             set_inputs(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      calc = get_calc(0);
      check_value($sformatf("b2b_calc_%0d", c), 65'(calc), 65'((c % 10) == 8));
      check_value($sformatf("b2b_busy_%0d", c), 65'(get_busy(0)), 65'((c % 10) != 9));
      if (calc) begin
        check_value($sformatf("b2b_result_%0d", c), get_result(0),
                    ref_result(8, 64'(oa[c/10]), 64'(ob[c/10]), oc[c/10], 1'b0));
        if (last_pulse >= 0) check_value($sformatf("b2b_spacing_%0d", c), 65'(c - last_pulse), 65'd10);
        last_pulse = c;
      end
    end
    set_inputs(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    fork
      for (int i = 0; i < 500; i++) begin : sweep16
        logic [64:0] rr;
        logic        sb;
        sb = 1'b0;
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
        sb = 1'($urandom_range(0, 1));
`endif
        do_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sb,
              $sformatf("w16_%0d", i), rr);
      end
      for (int j = 0; j < 500; j++) begin : sweep64
        logic [64:0] rr;
        logic        sb;
        sb = 1'b0;
`ifdef SUMMATOR_SERIAL_SUBTRACT_EN
        sb = 1'($urandom_range(0, 1));
`endif
        do_op(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sb,
              $sformatf("w64_%0d", j), rr);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
